cam_capture_win: RTL and testbench

Parametrised camera capture engine: the next generation of the camera-to-frame-buffer write path. It runs in the camera pixel-clock domain and turns the OV7670 byte stream (RGB565, two bytes per pixel) into pixel words with frame-buffer write addresses. Over the previous capture path it adds:
- configurable resolution;
- power-of-two decimation;
- selectable output format;
- frame start/done strobes;
- line/frame length checking.

---
 rtl/cam_capture_win.sv | 248 ++++++++++++++++++++++++
 tb/tb_cam_capture_win.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_win.sv
// Camera capture engine: pairs RGB565 bytes into pixel words with row-based frame-buffer addresses.
// Optional statistics counters are built only when CAM_CAPTURE_STATS_EN is defined.
module cam_capture_win #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DECIM    = 1,
    parameter int OUT_FMT  = 0,
    parameter int ADDR_W   = 19,
    localparam int DW      = (OUT_FMT == 0) ? 12 : 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [7:0]        i_pix_byte,
    output logic              o_pix_wr,
    output logic [ADDR_W-1:0] o_pix_addr,
    output logic [DW-1:0]     o_pix_data,
    output logic              o_frame_start,
    output logic              o_frame_done,
    output logic              o_busy,
    output logic              o_err_len,
    output logic [15:0]       o_frame_cnt,
    output logic [7:0]        o_err_cnt
);

    localparam int XW  = $clog2(H_ACTIVE + 2);
    localparam int YW  = $clog2(V_ACTIVE + 2);
    localparam int DSH = $clog2(DECIM);
    localparam logic [XW-1:0]     H_LIM    = XW'(H_ACTIVE);
    localparam logic [YW-1:0]     V_LIM    = YW'(V_ACTIVE);
    localparam logic [XW-1:0]     X_MASK   = XW'(DECIM - 1);
    localparam logic [YW-1:0]     Y_MASK   = YW'(DECIM - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE / DECIM);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} state_t;

    state_t              state_q, state_d;
    logic                vsync_q, vsync_d, vsync_p_q, vsync_p_d;
    logic                href_q, href_d, href_p_q, href_p_d;
    logic [7:0]          byte_q, byte_d, byte0_q, byte0_d;
    logic                phase_q, phase_d, err_q, err_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d, addr1_q, addr1_d;
    logic [DW-1:0]       data1_q, data1_d;
    logic                wr1_q, wr1_d, start1_q, start1_d, done1_q, done1_d;
    logic                pix_wr_q, pix_wr_d, frame_start_q, frame_start_d;
    logic                frame_done_q, frame_done_d, busy_q, busy_d, err_len_q, err_len_d;
    logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
    logic [DW-1:0]       pix_data_q, pix_data_d;

    logic          vs_fall, vs_rise, hr_rise, hr_fall;
    logic          line_phase, line_err, end_err, y_mod0;
    logic [XW-1:0] line_x;
    logic [YW-1:0] y_inc;
    logic [DW-1:0] fmt_data;

    assign vs_fall    = vsync_p_q & ~vsync_q;
    assign vs_rise    = vsync_q & ~vsync_p_q;
    assign hr_rise    = href_q & ~href_p_q;
    assign hr_fall    = href_p_q & ~href_q;
    assign line_x     = hr_rise ? '0 : x_q;
    assign line_phase = hr_rise ? 1'b0 : phase_q;
    assign line_err   = (x_q != H_LIM) | phase_q;
    assign y_inc      = (y_q > V_LIM) ? y_q : y_q + YW'(1);
    assign y_mod0     = (y_q & Y_MASK) == '0;
    // A line still open, or closing on the same cycle, counts toward the line total.
    assign end_err    = href_q | (href_p_q ? (line_err | (y_inc != V_LIM)) : (y_q != V_LIM));

    if (OUT_FMT == 1) begin : g_rgb565
        assign fmt_data = {byte0_q, byte_q};
    end else begin : g_rgb444
        assign fmt_data = {byte0_q[7:4], byte0_q[2:0], byte_q[7], byte_q[4:1]};
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a latch behind.
        vsync_d       = i_vsync;
        vsync_p_d     = vsync_q;
        href_d        = i_href;
        href_p_d      = href_q;
        byte_d        = i_pix_byte;
        state_d       = state_q;
        phase_d       = phase_q;
        byte0_d       = byte0_q;
        x_d           = x_q;
        y_d           = y_q;
        row_base_d    = row_base_q;
        err_d         = err_q;
        wr1_d         = 1'b0;
        addr1_d       = addr1_q;
        data1_d       = data1_q;
        start1_d      = 1'b0;
        done1_d       = 1'b0;
        pix_wr_d      = wr1_q;
        pix_addr_d    = addr1_q;
        pix_data_d    = data1_q;
        frame_start_d = start1_q;
        frame_done_d  = done1_q;
        busy_d        = (state_q == ACTIVE) | done1_q;
        err_len_d     = err_q;

        unique case (state_q)
            IDLE: begin
                if (i_en) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (!i_en) begin
                    state_d = IDLE;
                end else if (vs_fall) begin
                    state_d    = ACTIVE;
                    start1_d   = 1'b1;
                    x_d        = '0;
                    y_d        = '0;
                    row_base_d = '0;
                    err_d      = 1'b0;
                    phase_d    = 1'b0;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    state_d = i_en ? WAIT_FRAME : IDLE;
                    done1_d = 1'b1;
                    err_d   = err_q | end_err;
                end else if (href_q) begin
                    if (!line_phase) begin
                        byte0_d = byte_q;
                        phase_d = 1'b1;
                        x_d     = line_x;
                    end else begin
                        phase_d = 1'b0;
                        x_d     = (line_x > H_LIM) ? line_x : line_x + XW'(1);
                        if (line_x >= H_LIM) err_d = 1'b1;
                        if ((line_x < H_LIM) && (y_q < V_LIM) &&
                            ((line_x & X_MASK) == '0) && y_mod0) begin
                            wr1_d   = 1'b1;
                            addr1_d = row_base_q + ADDR_W'(line_x >> DSH);
                            data1_d = fmt_data;
                        end
                    end
                end else if (hr_fall) begin
                    err_d   = err_q | line_err | (y_q >= V_LIM);
                    phase_d = 1'b0;
                    y_d     = y_inc;
                    if ((y_q < V_LIM) && y_mod0) row_base_d = row_base_q + ROW_STEP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            vsync_q       <= 1'b0;
            vsync_p_q     <= 1'b0;
            href_q        <= 1'b0;
            href_p_q      <= 1'b0;
            byte_q        <= '0;
            byte0_q       <= '0;
            phase_q       <= 1'b0;
            err_q         <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            row_base_q    <= '0;
            addr1_q       <= '0;
            data1_q       <= '0;
            wr1_q         <= 1'b0;
            start1_q      <= 1'b0;
            done1_q       <= 1'b0;
            pix_wr_q      <= 1'b0;
            pix_addr_q    <= '0;
            pix_data_q    <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            err_len_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            vsync_q       <= vsync_d;
            vsync_p_q     <= vsync_p_d;
            href_q        <= href_d;
            href_p_q      <= href_p_d;
            byte_q        <= byte_d;
            byte0_q       <= byte0_d;
            phase_q       <= phase_d;
            err_q         <= err_d;
            x_q           <= x_d;
            y_q           <= y_d;
            row_base_q    <= row_base_d;
            addr1_q       <= addr1_d;
            data1_q       <= data1_d;
            wr1_q         <= wr1_d;
            start1_q      <= start1_d;
            done1_q       <= done1_d;
            pix_wr_q      <= pix_wr_d;
            pix_addr_q    <= pix_addr_d;
            pix_data_q    <= pix_data_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
            err_len_q     <= err_len_d;
        end
    end

    assign o_pix_wr      = pix_wr_q;
    assign o_pix_addr    = pix_addr_q;
    assign o_pix_data    = pix_data_q;
    assign o_frame_start = frame_start_q;
    assign o_frame_done  = frame_done_q;
    assign o_busy        = busy_q;
    assign o_err_len     = err_len_q;

`ifdef CAM_CAPTURE_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    // Counters step on the same edge that raises o_frame_done.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (done1_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
    assign o_err_cnt   = err_cnt_q;
`else
    assign o_frame_cnt = '0;
    assign o_err_cnt   = '0;
`endif

endmodule

// File: tb/tb_cam_capture_win.sv
// Scoreboard bench for cam_capture_win: two small-geometry instances (DECIM=1/RGB444 and
// DECIM=2/RGB565) share one camera stream; monitors pop expected writes and frame events.
module tb_cam_capture_win;

    localparam int H = 8;
    localparam int V = 6;

    typedef struct { int addr; int data; int cyc; } wr_t;
    typedef struct { int cyc; bit err; } ev_t;

    logic clk = 1'b0;
    logic rst, en, vsync, href;
    logic [7:0] pbyte;

    logic a_wr, a_start, a_done, a_busy, a_err;
    logic [5:0] a_addr;
    logic [11:0] a_data;
    logic [15:0] a_fcnt;
    logic [7:0] a_ecnt;
    logic b_wr, b_start, b_done, b_busy, b_err;
    logic [3:0] b_addr;
    logic [15:0] b_data;
    logic [15:0] b_fcnt;
    logic [7:0] b_ecnt;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int pat = 0;
    bit cap = 1'b0;
    int exp_fcnt = 0;
    int exp_ecnt = 0;

    wr_t qa[$], qb[$];
    int sa[$], sb[$];
    ev_t da[$], db[$];

    cam_capture_win #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(1), .OUT_FMT(0), .ADDR_W(6)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_vsync(vsync), .i_href(href), .i_pix_byte(pbyte),
        .o_pix_wr(a_wr), .o_pix_addr(a_addr), .o_pix_data(a_data), .o_frame_start(a_start),
        .o_frame_done(a_done), .o_busy(a_busy), .o_err_len(a_err), .o_frame_cnt(a_fcnt),
        .o_err_cnt(a_ecnt));

    cam_capture_win #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(2), .OUT_FMT(1), .ADDR_W(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_vsync(vsync), .i_href(href), .i_pix_byte(pbyte),
        .o_pix_wr(b_wr), .o_pix_addr(b_addr), .o_pix_data(b_data), .o_frame_start(b_start),
        .o_frame_done(b_done), .o_busy(b_busy), .o_err_len(b_err), .o_frame_cnt(b_fcnt),
        .o_err_cnt(b_ecnt));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin : mon_a
        wr_t w;
        ev_t e;
        int c;
        if (a_wr) begin
            check("a_wr_pending", 32'(qa.size() != 0), 1);
            if (qa.size() != 0) begin
                w = qa.pop_front();
                check("a_wr_addr", 32'(a_addr), w.addr);
                check("a_wr_data", 32'(a_data), w.data);
                check("a_wr_cycle", cyc, w.cyc);
            end
        end
        if (a_start) begin
            check("a_start_pending", 32'(sa.size() != 0), 1);
            if (sa.size() != 0) begin
                c = sa.pop_front();
                check("a_start_cycle", cyc, c);
                check("a_busy_at_start", 32'(a_busy), 1);
            end
        end
        if (a_done) begin
            check("a_done_pending", 32'(da.size() != 0), 1);
            if (da.size() != 0) begin
                e = da.pop_front();
                check("a_done_cycle", cyc, e.cyc);
                check("a_err_len", 32'(a_err), 32'(e.err));
                check("a_busy_at_done", 32'(a_busy), 1);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        wr_t w;
        ev_t e;
        int c;
        if (b_wr) begin
            check("b_wr_pending", 32'(qb.size() != 0), 1);
            if (qb.size() != 0) begin
                w = qb.pop_front();
                check("b_wr_addr", 32'(b_addr), w.addr);
                check("b_wr_data", 32'(b_data), w.data);
                check("b_wr_cycle", cyc, w.cyc);
            end
        end
        if (b_start) begin
            check("b_start_pending", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                c = sb.pop_front();
                check("b_start_cycle", cyc, c);
            end
        end
        if (b_done) begin
            check("b_done_pending", 32'(db.size() != 0), 1);
            if (db.size() != 0) begin
                e = db.pop_front();
                check("b_done_cycle", cyc, e.cyc);
                check("b_err_len", 32'(b_err), 32'(e.err));
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_a_outputs"}, 32'(|{a_wr, a_addr, a_data, a_start, a_done, a_busy, a_err,
                                         a_fcnt, a_ecnt}), 0);
        check({tag, "_b_outputs"}, 32'(|{b_wr, b_addr, b_data, b_start, b_done, b_busy, b_err,
                                         b_fcnt, b_ecnt}), 0);
    endtask

    task automatic check_counters();
`ifdef CAM_CAPTURE_STATS_EN
        check("a_frame_cnt", 32'(a_fcnt), exp_fcnt);
        check("a_err_cnt", 32'(a_ecnt), exp_ecnt);
        check("b_frame_cnt", 32'(b_fcnt), exp_fcnt);
`else
        check("a_frame_cnt", 32'(a_fcnt), 0);
        check("a_err_cnt", 32'(a_ecnt), 0);
        check("b_frame_cnt", 32'(b_fcnt), 0);
`endif
    endtask

    task automatic pix_bytes(input int x, input int y, output logic [7:0] b0, output logic [7:0] b1);
        case (pat)
            0: begin b0 = 8'hF8; b1 = 8'h1F; end
            1: begin b0 = 8'h12; b1 = 8'h34; end
            default: begin
                b0 = 8'((x * 37 + y * 11 + 5) & 255);
                b1 = 8'((x * 53 + y * 7 + 9) & 255);
            end
        endcase
    endtask

    // One camera line; expected writes are pushed as byte1 is driven.
    task automatic send_line(input int y, input int npix, input bit keep_href);
        logic [7:0] b0, b1;
        logic [4:0] r, bl;
        logic [5:0] g;
        wr_t w;
        for (int x = 0; x < npix; x++) begin
            pix_bytes(x, y, b0, b1);
            @(negedge clk); href = 1'b1; pbyte = b0;
            @(negedge clk); pbyte = b1;
            if (cap && x < H && y < V) begin
                r = b0[7:3];
                g = {b0[2:0], b1[7:5]};
                bl = b1[4:0];
                w.addr = y * H + x;
                w.data = int'({r[4:1], g[5:2], bl[4:1]});
                w.cyc = cyc + 3;
                qa.push_back(w);
                if (x % 2 == 0 && y % 2 == 0) begin
                    w.addr = (y / 2) * (H / 2) + x / 2;
                    w.data = int'({b0, b1});
                    qb.push_back(w);
                end
            end
        end
        if (!keep_href) begin
            @(negedge clk); href = 1'b0; pbyte = 8'h00;
            repeat (3) @(negedge clk);
        end
    endtask

    // nl lines; line sy has sn pixels; reset before line rst_y; i_en dropped before line drop_y;
    // VSYNC rises while HREF is still high at the end of line cut_y. -1 disables an option.
    task automatic frame(input int nl, input int sy, input int sn, input int rst_y,
                         input int drop_y, input int cut_y, input bit exp_cap);
        bit err;
        int n;
        ev_t e;
        cap = exp_cap;
        err = (nl != V);
        @(negedge clk); vsync = 1'b0;
        if (cap) begin sa.push_back(cyc + 3); sb.push_back(cyc + 3); end
        repeat (3) @(negedge clk);
        for (int y = 0; y < nl; y++) begin
            if (y == rst_y) begin
                @(negedge clk); rst = 1'b1;
                @(negedge clk);
                check_outputs_zero("mid_reset");
                rst = 1'b0;
                cap = 1'b0;
                qa.delete(); qb.delete(); sa.delete(); sb.delete(); da.delete(); db.delete();
                exp_fcnt = 0;
                exp_ecnt = 0;
            end
            if (y == drop_y) en = 1'b0;
            n = (y == sy) ? sn : H;
            if (n != H) err = 1'b1;
            send_line(y, n, y == cut_y);
            if (y == cut_y) begin
                err = 1'b1;
                break;
            end
        end
        @(negedge clk); vsync = 1'b1;
        if (cap) begin
            e.cyc = cyc + 3;
            e.err = err;
            da.push_back(e);
            db.push_back(e);
            exp_fcnt++;
            if (err) exp_ecnt++;
        end
        if (cut_y >= 0) begin
            @(negedge clk); href = 1'b0; pbyte = 8'h00;
        end
        repeat (8) @(negedge clk);
        check("a_events_drained", qa.size() + sa.size() + da.size(), 0);
        check("b_events_drained", qb.size() + sb.size() + db.size(), 0);
        check("a_idle_busy", 32'(a_busy), 0);
        check_counters();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; en = 1'b1; vsync = 1'b1; href = 1'b0; pbyte = 8'h00;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        pat = 0; frame(V, -1, 0, -1, -1, -1, 1'b1);     // full frame, 0xF0F / 0xF81F
        pat = 2; frame(V, 2, 7, -1, -1, -1, 1'b1);      // short line 2, later rows keep addresses
        frame(V, 1, 10, -1, -1, -1, 1'b1);              // long line 1, extra pixels dropped
        frame(V + 1, -1, 0, -1, -1, -1, 1'b1);          // extra line not written
        frame(V, -1, 0, 3, -1, -1, 1'b1);               // reset mid-frame: no done
        pat = 1; frame(V, -1, 0, -1, -1, -1, 1'b1);     // restart at address 0, 0x14A / 0x1234
        pat = 2; frame(V, -1, 0, -1, 2, -1, 1'b1);      // i_en dropped: frame still completes
        frame(V, -1, 0, -1, -1, -1, 1'b0);              // idle: nothing captured
        en = 1'b1;
        repeat (2) @(negedge clk);
        frame(V, -1, 0, -1, -1, 4, 1'b1);               // VSYNC rises during line 4
        pat = 0; frame(V, -1, 0, -1, -1, -1, 1'b1);     // clean frame after error frames

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
